bram_burst_arbiter: RTL and testbench

- Shares one port of the dual-port feature-map BRAM (16-bit words, 3840 deep) between two requesters: requester 0 is the host/DMA loader and requester 1 is the accelerator engine.
- Each requester posts a burst descriptor (read or write, base address, length). The block arbitrates round-robin, generates sequential addresses and streams data to or from the BRAM port.
- It sits directly in front of one BRAM port. The other BRAM port is untouched.

---
 rtl/bram_burst_arbiter_pkg.sv | 24 ++
 rtl/bram_burst_arbiter_addr_gen.sv | 42 ++++
 rtl/bram_burst_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bram_burst_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_burst_arbiter_pkg.sv
// Shared types and defaults for the feature-map BRAM burst arbiter.
// Holds the FSM state encoding, default geometry and the round-robin pick.
package bram_burst_arbiter_pkg;

    localparam int DWIDTH_DEF   = 16;
    localparam int AWIDTH_DEF   = 12;
    localparam int MEM_SIZE_DEF = 3840;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    // On a collision the requester that did not win last time is chosen.
    function automatic logic pick_owner(input logic req_a, input logic req_b, input logic rr_last);
        if (req_a && req_b) begin
            return ~rr_last;
        end
        return req_b;
    endfunction

endpackage

// File: rtl/bram_burst_arbiter_addr_gen.sv
// Burst address/length counters: sequential BRAM addresses wrapping at MEM_SIZE,
// with a flag marking the final word of the burst.
module bram_burst_arbiter_addr_gen
    import bram_burst_arbiter_pkg::*;
#(
    parameter int AWIDTH   = AWIDTH_DEF,
    parameter int MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [AWIDTH-1:0] base,
    input  logic [AWIDTH-1:0] len,
    input  logic              advance,
    output logic [AWIDTH-1:0] addr,
    output logic              last
);

    localparam logic [AWIDTH-1:0] ADDR_LIMIT = AWIDTH'(MEM_SIZE);
    localparam logic [AWIDTH-1:0] ADDR_LAST  = AWIDTH'(MEM_SIZE - 1);

    logic [AWIDTH-1:0] addr_reg;
    logic [AWIDTH-1:0] remaining_reg;

    // Out-of-range bases are clamped to 0 so a burst never addresses past the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
        end else if (load) begin
            addr_reg      <= (base >= ADDR_LIMIT) ? '0 : base;
            remaining_reg <= len;
        end else if (advance) begin
            addr_reg      <= (addr_reg == ADDR_LAST) ? '0 : addr_reg + 1'b1;
            remaining_reg <= remaining_reg - 1'b1;
        end
    end

    assign addr = addr_reg;
    assign last = (remaining_reg == AWIDTH'(1));

endmodule

// File: rtl/bram_burst_arbiter.sv
// Round-robin burst arbiter sharing one feature-map BRAM port between the
// host/DMA loader (requester 0) and the accelerator engine (requester 1).
module bram_burst_arbiter
    import bram_burst_arbiter_pkg::*;
#(
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int AWIDTH   = AWIDTH_DEF,
    parameter int MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [AWIDTH-1:0] base0,
    input  logic [AWIDTH-1:0] base1,
    input  logic [AWIDTH-1:0] len0,
    input  logic [AWIDTH-1:0] len1,
    output logic              ack0,
    output logic              ack1,
    output logic              done0,
    output logic              done1,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic [DWIDTH-1:0] wdata1,
    input  logic              wvalid0,
    input  logic              wvalid1,
    output logic              wready0,
    output logic              wready1,
    output logic [DWIDTH-1:0] rdata0,
    output logic [DWIDTH-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [AWIDTH-1:0] bram_addr,
    output logic              bram_ce,
    output logic              bram_we,
    output logic [DWIDTH-1:0] bram_d,
    input  logic [DWIDTH-1:0] bram_q
);

    state_t state_reg, state_next;
    logic   owner_reg, owner_next;
    logic   wr_reg, wr_next;
    logic   rr_last_reg, rr_last_next;
    logic   rvalid_reg, rvalid_next;

    logic              grant;
    logic              grant_wr;
    logic [AWIDTH-1:0] grant_base;
    logic [AWIDTH-1:0] grant_len;
    logic              load;
    logic              advance;
    logic              last;
    logic [AWIDTH-1:0] cur_addr;
    logic              wvalid_sel;
    logic [DWIDTH-1:0] wdata_sel;
    logic [1:0]        ack_vec;
    logic [1:0]        done_vec;
    logic [1:0]        wready_vec;

    assign grant      = pick_owner(req0, req1, rr_last_reg);
    assign grant_wr   = grant ? wr1 : wr0;
    assign grant_base = grant ? base1 : base0;
    assign grant_len  = grant ? len1 : len0;
    assign wvalid_sel = owner_reg ? wvalid1 : wvalid0;
    assign wdata_sel  = owner_reg ? wdata1 : wdata0;

    bram_burst_arbiter_addr_gen #(
        .AWIDTH   (AWIDTH),
        .MEM_SIZE (MEM_SIZE)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .base    (grant_base),
        .len     (grant_len),
        .advance (advance),
        .addr    (cur_addr),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            owner_reg   <= 1'b0;
            wr_reg      <= 1'b0;
            rr_last_reg <= 1'b1;
            rvalid_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            wr_reg      <= wr_next;
            rr_last_reg <= rr_last_next;
            rvalid_reg  <= rvalid_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        wr_next      = wr_reg;
        rr_last_next = rr_last_reg;
        load         = 1'b0;
        advance      = 1'b0;
        ack_vec      = 2'b00;
        done_vec     = 2'b00;
        wready_vec   = 2'b00;
        bram_ce      = 1'b0;
        bram_we      = 1'b0;
        bram_d       = '0;
        unique case (state_reg)
            IDLE: begin
                // No grant while reset is held, so a pending req cannot see a stray ack.
                if (rst_n && (req0 || req1)) begin
                    load           = 1'b1;
                    owner_next     = grant;
                    wr_next        = grant_wr;
                    rr_last_next   = grant;
                    ack_vec[grant] = 1'b1;
                    state_next     = (grant_len != '0) ? BURST : FIN;
                end
            end
            BURST: begin
                if (wr_reg) begin
                    wready_vec[owner_reg] = 1'b1;
                    if (wvalid_sel) begin
                        bram_ce = 1'b1;
                        bram_we = 1'b1;
                        bram_d  = wdata_sel;
                        advance = 1'b1;
                        if (last) begin
                            state_next = FIN;
                        end
                    end
                end else begin
                    bram_ce = 1'b1;
                    advance = 1'b1;
                    if (last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_next = FIN;
            end
            FIN: begin
                done_vec[owner_reg] = 1'b1;
                state_next          = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // BRAM output is registered, so read data for an issue lands one cycle later.
    assign rvalid_next = (state_reg == BURST) && !wr_reg;

    assign bram_addr = cur_addr;
    assign ack0      = ack_vec[0];
    assign ack1      = ack_vec[1];
    assign done0     = done_vec[0];
    assign done1     = done_vec[1];
    assign wready0   = wready_vec[0];
    assign wready1   = wready_vec[1];
    assign rvalid0   = rvalid_reg && !owner_reg;
    assign rvalid1   = rvalid_reg && owner_reg;
    assign rdata0    = owner_reg ? '0 : bram_q;
    assign rdata1    = owner_reg ? bram_q : '0;

endmodule

// File: tb/tb_bram_burst_arbiter.sv
// Scoreboard bench for bram_burst_arbiter: stimulus pushes expected BRAM accesses
// and read data, a negedge monitor pops and compares them as the DUT produces them.
module tb_bram_burst_arbiter;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int MS = 3840;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]    req_v = '0;
    logic [1:0]    wr_v = '0;
    logic [1:0]    wvalid_v = '0;
    logic [AW-1:0] base_v [2];
    logic [AW-1:0] len_v [2];
    logic [DW-1:0] wdata_v [2];

    logic ack0, ack1, done0, done1, wready0, wready1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] bram_addr;
    logic          bram_ce, bram_we;
    logic [DW-1:0] bram_d;
    logic [DW-1:0] bram_q;

    logic [1:0] ack_v, done_v, wready_v, rvalid_v;
    assign ack_v    = {ack1, ack0};
    assign done_v   = {done1, done0};
    assign wready_v = {wready1, wready0};
    assign rvalid_v = {rvalid1, rvalid0};

    bram_burst_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req_v[0]), .req1(req_v[1]),
        .wr0(wr_v[0]), .wr1(wr_v[1]),
        .base0(base_v[0]), .base1(base_v[1]),
        .len0(len_v[0]), .len1(len_v[1]),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
        .wvalid0(wvalid_v[0]), .wvalid1(wvalid_v[1]),
        .wready0(wready0), .wready1(wready1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .bram_addr(bram_addr), .bram_ce(bram_ce), .bram_we(bram_we),
        .bram_d(bram_d), .bram_q(bram_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port BRAM with registered read.
    logic [DW-1:0] bram_mem [4096];
    always @(posedge clk) begin
        if (bram_ce) begin
            if (bram_we) bram_mem[bram_addr] <= bram_d;
            else         bram_q <= bram_mem[bram_addr];
        end
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;
    typedef struct {
        int            r;
        logic [DW-1:0] d;
    } rd_t;

    acc_t exp_acc[$];
    rd_t  exp_rd[$];
    logic [DW-1:0] shadow [4096];
    logic [DW-1:0] wbuf [8];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        acc_t ea;
        rd_t  er;
        if (bram_ce) begin
            if (exp_acc.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_bram_access: got addr %0d we %0b expected no access (cycle %0d)",
                         bram_addr, bram_we, cyc);
            end else begin
                ea = exp_acc.pop_front();
                chk("bram_we", 32'(bram_we), 32'(ea.we));
                chk("bram_addr", 32'(bram_addr), 32'(ea.a));
                if (ea.we) chk("bram_d", 32'(bram_d), 32'(ea.d));
            end
        end
        if (rvalid0 || rvalid1) begin
            if (exp_rd.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rvalid: got rvalid %b expected none (cycle %0d)", rvalid_v, cyc);
            end else begin
                er = exp_rd.pop_front();
                chk("rvalid_owner", 32'(rvalid_v), (er.r == 0) ? 32'd1 : 32'd2);
                chk("rdata", (er.r == 0) ? 32'(rdata0) : 32'(rdata1), 32'(er.d));
            end
        end
    end

    task automatic do_burst(input int r, input bit w, input int base, input int len, input bit stall);
        int  a, t, idx, k, exp_done;
        bit  got;
        acc_t ea;
        rd_t  er;
        a = (base >= MS) ? 0 : base;
        for (int i = 0; i < len; i++) begin
            ea.we = w;
            ea.a  = AW'(a);
            ea.d  = w ? wbuf[i] : '0;
            exp_acc.push_back(ea);
            if (w) begin
                shadow[a] = wbuf[i];
            end else begin
                er.r = r;
                er.d = shadow[a];
                exp_rd.push_back(er);
            end
            a = (a == MS - 1) ? 0 : a + 1;
        end
        @(posedge clk); #1;
        req_v[r]  = 1'b1;
        wr_v[r]   = w;
        base_v[r] = AW'(base);
        len_v[r]  = AW'(len);
        got = 0;
        t   = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack_v[r]) begin
                got = 1;
                t   = cyc;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        if (!got) begin
            req_v[r] = 1'b0;
            return;
        end
        chk("ack_other_low", 32'(ack_v[1-r]), 32'd0);
        idx = 0;
        k   = 0;
        got = 0;
        for (int i = 0; i < 4 * len + 20 && !got; i++) begin
            @(posedge clk); #1;
            req_v[r] = 1'b0;
            if (w && idx < len) begin
                wvalid_v[r] = stall ? (k % 2 == 0) : 1'b1;
                wdata_v[r]  = wbuf[idx];
            end else begin
                wvalid_v[r] = 1'b0;
            end
            k++;
            @(negedge clk);
            if (w && wvalid_v[r] && wready_v[r]) idx++;
            else if (w && idx < len && !wvalid_v[r]) chk("stall_ce_low", 32'(bram_ce), 32'd0);
            if (!w) chk("rvalid_window", 32'(rvalid_v[r]), 32'(cyc >= t + 2 && cyc <= t + len + 1));
            chk("other_quiet", 32'({wready_v[1-r], rvalid_v[1-r], ack_v[1-r]}), 32'd0);
            if (done_v[r]) got = 1;
        end
        wvalid_v[r] = 1'b0;
        if (len == 0)   exp_done = t + 1;
        else if (!w)    exp_done = t + len + 2;
        else if (stall) exp_done = t + 2 * len;
        else            exp_done = t + len + 1;
        chk("done_seen", 32'(got), 32'd1);
        chk("done_latency", 32'(cyc - t), 32'(exp_done - t));
        $display("burst r%0d %s base=%0d len=%0d stall=%0d ack@%0d done@%0d",
                 r, w ? "write" : "read", base, len, stall, t, cyc);
    endtask

    logic [3:0] collide_tbl [5];

    initial begin : stim
        acc_t ea;
        rd_t  er;
        int   t;
        bit   got;
        for (int i = 0; i < 2; i++) begin
            base_v[i]  = '0;
            len_v[i]   = '0;
            wdata_v[i] = '0;
        end
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({ack0, ack1, done0, done1, wready0, wready1, rvalid0, rvalid1, bram_ce, bram_we}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Collision from reset with zero-length bursts: {ack0,ack1,done0,done1} per cycle.
        collide_tbl[0] = 4'b1000;
        collide_tbl[1] = 4'b0010;
        collide_tbl[2] = 4'b0100;
        collide_tbl[3] = 4'b0001;
        collide_tbl[4] = 4'b1000;
        @(posedge clk); #1;
        req_v = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("collide_c%0d", i), 32'({ack0, ack1, done0, done1}), 32'(collide_tbl[i]));
        end
        @(posedge clk); #1;
        req_v = 2'b00;
        @(negedge clk);
        chk("collide_final_done0", 32'({done0, done1}), 32'd2);
        $display("collision sequence ack0 done0 ack1 done1 ack0 done0 checked");

        // Write then read back.
        for (int i = 0; i < 4; i++) wbuf[i] = DW'(16'h00A0 + i);
        do_burst(0, 1, 10, 4, 0);
        do_burst(0, 0, 10, 4, 0);

        // Write with wvalid toggling.
        for (int i = 0; i < 3; i++) wbuf[i] = DW'(16'h00B0 + i);
        do_burst(1, 1, 100, 3, 1);
        do_burst(1, 0, 100, 3, 0);

        // Wrap at MEM_SIZE.
        for (int i = 0; i < 4; i++) wbuf[i] = DW'(16'h00C0 + i);
        do_burst(0, 1, 3838, 4, 0);
        do_burst(1, 0, 3838, 4, 0);

        // Zero length.
        do_burst(1, 0, 55, 0, 0);

        // Base clamp.
        wbuf[0] = 16'h00D0;
        do_burst(1, 1, 4000, 1, 0);
        do_burst(0, 0, 0, 1, 0);

        // Reset during a read burst, at its 2nd word.
        ea.we = 1'b0; ea.d = '0;
        ea.a = 12'd10; exp_acc.push_back(ea);
        ea.a = 12'd11; exp_acc.push_back(ea);
        er.r = 0; er.d = shadow[10]; exp_rd.push_back(er);
        @(posedge clk); #1;
        req_v[0] = 1'b1; wr_v[0] = 1'b0; base_v[0] = 12'd10; len_v[0] = 12'd4;
        got = 0; t = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack0) begin got = 1; t = cyc; end
        end
        chk("rst_burst_ack", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_outputs", 32'({ack0, ack1, done0, done1, wready0, wready1, rvalid0, rvalid1, bram_ce, bram_we}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid_no_done", 32'({done0, done1}), 32'd0);
        end
        $display("reset mid-burst ack@%0d aborted", t);
        do_burst(0, 0, 10, 1, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("exp_acc_drained", 32'(exp_acc.size()), 32'd0);
        chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
        $fatal(1, "timeout");
    end

endmodule
